// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst slave backed by a dual-port word memory; independent read and write engines.
// Define AXI_MEM_BACKPRESSURE_EN to throttle the ready/valid outputs with a 16-bit LFSR.
module axi_mem_responder #(
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 40,
  parameter int MEM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [7:0]            axi_awlen,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [DATA_WIDTH-1:0] axi_wdata,
  input  logic                  axi_wlast,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [7:0]            axi_arlen,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rlast,
  output logic                  axi_rvalid,
  input  logic                  axi_rready
);

  localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W    = $clog2(MEM_DEPTH);
  localparam int PTR_W    = ADDR_WIDTH - ADDR_LSB + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} rstate_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  wstate_t          wstate_q, wstate_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [7:0]       wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic             werr_q, werr_d;
  logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;

  rstate_t               rstate_q, rstate_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d, lat_q, lat_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic bp_ready, bp_rvalid;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, werr_beat, mem_we, rd_load;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{axi_awaddr[ADDR_LSB-1:0], axi_araddr[ADDR_LSB-1:0]};

`ifdef AXI_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        rshown_q, rshown_d;

  // rshown remembers that the current beat was already presented, so it is never withdrawn.
  always_comb begin
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    rshown_d = rshown_q;
    if (!rvalid_q || r_hs) rshown_d = 1'b0;
    else if (axi_rvalid)   rshown_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= 16'hACE1;
      rshown_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      rshown_q <= rshown_d;
    end
  end

  assign bp_ready  = lfsr_q[0];
  assign bp_rvalid = lfsr_q[1] | rshown_q;
`else
  assign bp_ready  = 1'b1;
  assign bp_rvalid = 1'b1;
`endif

  assign axi_awready = awready_q & bp_ready;
  assign axi_wready  = wready_q & bp_ready;
  assign axi_arready = arready_q & bp_ready;
  assign axi_rvalid  = rvalid_q & bp_rvalid;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_rlast   = rlast_q;

  assign aw_hs = axi_awvalid & axi_awready;
  assign w_hs  = axi_wvalid & axi_wready;
  assign b_hs  = bvalid_q & axi_bready;
  assign ar_hs = axi_arvalid & axi_arready;
  assign r_hs  = axi_rvalid & axi_rready;

  // The burst always runs awlen+1 beats; wlast misplacement only poisons the response.
  assign werr_beat = (wptr_q >= DEPTH_P) | (axi_wlast != (wcnt_q == wlen_q));
  assign mem_we    = (wstate_q == W_DATA) & w_hs & (wptr_q < DEPTH_P);

  always_comb begin
    wstate_d  = wstate_q;
    wptr_d    = wptr_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (wstate_q)
      W_IDLE: if (aw_hs) begin
        wstate_d  = W_DATA;
        wptr_d    = {1'b0, axi_awaddr[ADDR_WIDTH-1:ADDR_LSB]};
        wlen_d    = axi_awlen;
        wcnt_d    = 8'd0;
        werr_d    = 1'b0;
        awready_d = 1'b0;
        wready_d  = 1'b1;
      end
      W_DATA: if (w_hs) begin
        werr_d = werr_q | werr_beat;
        wptr_d = wptr_q + PTR_W'(1);
        wcnt_d = wcnt_q + 8'd1;
        if (wcnt_q == wlen_q) begin
          wstate_d = W_RESP;
          wready_d = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = (werr_q | werr_beat) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: if (b_hs) begin
        wstate_d  = W_IDLE;
        bvalid_d  = 1'b0;
        bresp_d   = RESP_OKAY;
        awready_d = 1'b1;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Next beat is fetched combinationally so a same-edge write leaves the old word visible.
  always_comb begin
    rstate_d  = rstate_q;
    rptr_d    = rptr_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    lat_d     = lat_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rd_load   = 1'b0;
    case (rstate_q)
      R_IDLE: if (ar_hs) begin
        rstate_d  = R_LAT;
        rptr_d    = {1'b0, axi_araddr[ADDR_WIDTH-1:ADDR_LSB]};
        rlen_d    = axi_arlen;
        rbeat_d   = 8'd0;
        lat_d     = 8'(READ_LATENCY - 1);
        arready_d = 1'b0;
      end
      R_LAT: begin
        if (lat_q == 8'd0) begin
          rstate_d = R_DATA;
          rd_load  = 1'b1;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
      R_DATA: if (r_hs) begin
        if (rlast_q) begin
          rstate_d  = R_IDLE;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          rresp_d   = RESP_OKAY;
          rdata_d   = '0;
          arready_d = 1'b1;
        end else begin
          rptr_d  = rptr_q + PTR_W'(1);
          rbeat_d = rbeat_q + 8'd1;
          rd_load = 1'b1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    if (rd_load) begin
      rvalid_d = 1'b1;
      rlast_d  = (rbeat_d == rlen_q);
      if (rptr_d >= DEPTH_P) begin
        rdata_d = '0;
        rresp_d = RESP_SLVERR;
      end else begin
        rdata_d = mem[rptr_d[IDX_W-1:0]];
        rresp_d = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      wptr_q    <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rstate_q  <= R_IDLE;
      rptr_q    <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      lat_q     <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      wptr_q    <= wptr_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      rptr_q    <= rptr_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      lat_q     <= lat_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage is deliberately not reset so contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q[IDX_W-1:0]] <= axi_wdata;
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: a burst vector table plus hand-written
// sequences for stalls, simultaneous AW/AR, B backpressure and mid-burst reset.
module tb_axi_mem_responder;

  localparam int DATA_WIDTH = 256;
  localparam int ADDR_WIDTH = 40;
  localparam int GUARD      = 100;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [ADDR_WIDTH-1:0] axi_awaddr, axi_araddr;
  logic [7:0]            axi_awlen, axi_arlen;
  logic                  axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic [DATA_WIDTH-1:0] axi_wdata, axi_rdata;
  logic [1:0]            axi_bresp, axi_rresp;
  logic                  axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic                  axi_rlast, axi_rvalid, axi_rready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         wr;
    logic [39:0] addr;
    int         len;
    logic [255:0] base;
    int         badlast;
    logic [1:0] exp_bresp;
    int         oor_from;
  } vec_t;

  vec_t vecs[11];

  axi_mem_responder #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(1024), .READ_LATENCY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [263:0] act, input logic [263:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_burst(input logic [39:0] addr, input int len, input logic [255:0] base,
                             input int badlast, output logic [1:0] resp);
    int g;
    axi_awaddr = addr; axi_awlen = 8'(len); axi_awvalid = 1'b1;
    g = 0;
    while (!axi_awready && g < GUARD) begin @(negedge clk); g++; end
    if (g >= GUARD) check_output("aw_timeout", 0, 1);
    @(negedge clk);
    axi_awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      axi_wvalid = 1'b1;
      axi_wdata  = base + 256'(k);
      axi_wlast  = (badlast < 0) ? (k == len) : (k == badlast);
      g = 0;
      while (!axi_wready && g < GUARD) begin @(negedge clk); g++; end
      if (g >= GUARD) check_output("w_timeout", 0, 1);
      @(negedge clk);
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    g = 0;
    while (!axi_bvalid && g < GUARD) begin @(negedge clk); g++; end
    if (g >= GUARD) check_output("b_timeout", 0, 1);
    resp = axi_bresp;
    axi_bready = 1'b1;
    @(negedge clk);
    axi_bready = 1'b0;
    check_output("b_done_idle", {axi_bvalid, axi_awready}, 2'b01);
  endtask

  task automatic read_burst(input logic [39:0] addr, input int len, input logic [255:0] base,
                            input int oor_from, input logic [15:0] rdy_pat);
    int g, lat, beat, cyc;
    bit stalled;
    logic [258:0] held, expv;
    axi_araddr = addr; axi_arlen = 8'(len); axi_arvalid = 1'b1;
    g = 0;
    while (!axi_arready && g < GUARD) begin @(negedge clk); g++; end
    if (g >= GUARD) check_output("ar_timeout", 0, 1);
    @(negedge clk);
    axi_arvalid = 1'b0;
    lat = 0;
    while (!axi_rvalid && lat < GUARD) begin @(negedge clk); lat++; end
    check_output($sformatf("r_latency@%0h", addr), lat, 2);
    beat = 0; cyc = 0; stalled = 0; held = '0;
    while (beat <= len && cyc < 200) begin
      axi_rready = rdy_pat[cyc % 16];
      if (stalled) begin
        check_output($sformatf("r_hold@%0h.%0d", addr, beat),
                     {axi_rvalid, axi_rresp, axi_rlast, axi_rdata}, {1'b1, held});
      end else if (axi_rvalid) begin
        expv = {(beat >= oor_from) ? 2'b10 : 2'b00, beat == len,
                (beat >= oor_from) ? 256'd0 : base + 256'(beat)};
        check_output($sformatf("r_beat@%0h.%0d", addr, beat),
                     {axi_rresp, axi_rlast, axi_rdata}, expv);
      end
      if (axi_rvalid && axi_rready) begin
        beat++; stalled = 0;
      end else if (axi_rvalid) begin
        stalled = 1; held = {axi_rresp, axi_rlast, axi_rdata};
      end
      @(negedge clk);
      cyc++;
    end
    axi_rready = 1'b0;
    if (beat <= len) check_output("r_beats_timeout", beat, len + 1);
    check_output($sformatf("r_done_idle@%0h", addr), {axi_rvalid, axi_arready}, 2'b01);
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    logic [1:0] resp;
    if (v.wr) begin
      write_burst(v.addr, v.len, v.base, v.badlast, resp);
      check_output($sformatf("bresp_vec%0d", idx), resp, v.exp_bresp);
    end else begin
      read_burst(v.addr, v.len, v.base, v.oor_from, 16'hFFFF);
    end
  endtask

  initial begin
    int g;
    vecs[0]  = '{1'b1, 40'h0,    0, 256'hAA,  -1, 2'b00, 256};
    vecs[1]  = '{1'b1, 40'h40,   3, 256'h1,   -1, 2'b00, 256};
    vecs[2]  = '{1'b0, 40'h40,   3, 256'h1,   -1, 2'b00, 256};
    vecs[3]  = '{1'b1, 40'h7FE0, 1, 256'h100, -1, 2'b10, 256};
    vecs[4]  = '{1'b0, 40'h7FE0, 1, 256'h100, -1, 2'b00, 1};
    vecs[5]  = '{1'b0, 40'h0,    0, 256'hAA,  -1, 2'b00, 256};
    vecs[6]  = '{1'b1, 40'h200,  2, 256'h20,   1, 2'b10, 256};
    vecs[7]  = '{1'b0, 40'h200,  2, 256'h20,  -1, 2'b00, 256};
    vecs[8]  = '{1'b1, 40'h400,  1, 256'h30,   5, 2'b10, 256};
    vecs[9]  = '{1'b0, 40'h400,  1, 256'h30,  -1, 2'b00, 256};
    vecs[10] = '{1'b0, 40'h8000, 0, 256'h0,   -1, 2'b00, 0};

    rst_n = 1'b0;
    axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
    axi_araddr = '0; axi_arlen = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_readies", {axi_awready, axi_arready, axi_wready}, 3'b110);
    check_output("reset_resp", {axi_bvalid, axi_bresp, axi_rvalid, axi_rresp, axi_rlast}, 7'd0);
    check_output("reset_rdata", axi_rdata, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    axi_wvalid = 1'b1; axi_wdata = 256'hDEAD; axi_wlast = 1'b1;
    repeat (2) @(negedge clk);
    check_output("w_before_aw", {axi_wready, axi_bvalid, axi_awready}, 3'b001);
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) apply_stimulus(i, vecs[i]);

    read_burst(40'h40, 3, 256'h1, 256, 16'h9999);

    check_output("simul_readies", {axi_awready, axi_arready}, 2'b11);
    axi_awaddr = 40'h0; axi_awlen = 8'd0; axi_awvalid = 1'b1;
    axi_araddr = 40'h0; axi_arlen = 8'd0; axi_arvalid = 1'b1;
    @(negedge clk);
    axi_awvalid = 1'b0; axi_arvalid = 1'b0;
    check_output("simul_both_taken", {axi_awready, axi_arready, axi_wready}, 3'b001);
    g = 0;
    while (!axi_rvalid && g < GUARD) begin @(negedge clk); g++; end
    check_output("simul_read_old", {axi_rvalid, axi_rdata}, {1'b1, 256'hAA});
    axi_rready = 1'b1;
    @(negedge clk);
    axi_rready = 1'b0;
    axi_wvalid = 1'b1; axi_wdata = 256'hBB; axi_wlast = 1'b1;
    g = 0;
    while (!axi_wready && g < GUARD) begin @(negedge clk); g++; end
    @(negedge clk);
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
    g = 0;
    while (!axi_bvalid && g < GUARD) begin @(negedge clk); g++; end
    for (int c = 0; c < 5; c++) begin
      check_output($sformatf("b_hold%0d", c), {axi_bvalid, axi_bresp}, 3'b100);
      @(negedge clk);
    end
    axi_bready = 1'b1;
    @(negedge clk);
    axi_bready = 1'b0;
    check_output("b_released", axi_bvalid, 1'b0);
    read_burst(40'h0, 0, 256'hBB, 256, 16'hFFFF);

    axi_araddr = 40'h40; axi_arlen = 8'd3; axi_arvalid = 1'b1;
    g = 0;
    while (!axi_arready && g < GUARD) begin @(negedge clk); g++; end
    @(negedge clk);
    axi_arvalid = 1'b0;
    g = 0;
    while (!axi_rvalid && g < GUARD) begin @(negedge clk); g++; end
    axi_rready = 1'b1;
    @(negedge clk);
    axi_rready = 1'b0;
    check_output("rst_mid_beat2", {axi_rvalid, axi_rdata}, {1'b1, 256'h2});
    rst_n = 1'b0;
    @(negedge clk);
    check_output("rst_mid_idle", {axi_rvalid, axi_arready, axi_awready}, 3'b011);
    rst_n = 1'b1;
    @(negedge clk);
    read_burst(40'h40, 3, 256'h1, 256, 16'hFFFF);
    read_burst(40'h0, 0, 256'hBB, 256, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
